// File: rtl/dpram_generic.sv
// True dual-port RAM with byte enables on one clock, selectable read-during-write,
// optional output register and a post-reset clear sequencer.
module dpram_generic #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int OUTREG         = 0,
  parameter int RDW_NEW        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             init_done,
  input  logic                             en_a,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
  input  logic [DATA_WIDTH-1:0]            di_a,
  output logic [DATA_WIDTH-1:0]            do_a,
  output logic                             valid_a,
  input  logic                             en_b,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
  input  logic [DATA_WIDTH-1:0]            di_b,
  output logic [DATA_WIDTH-1:0]            do_b,
  output logic                             valid_b
);
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    acc_a, acc_b;
  logic [DATA_WIDTH-1:0]   rd_a, rd_b;
  logic [DATA_WIDTH-1:0]   q1_a, q1_b;
  logic                    v1_a, v1_b;

  // Handshake: en_x is a one-cycle request with no backpressure, honoured only
  // while init_done is high; valid_x pulses exactly LAT cycles later with do_x.
  assign acc_a = en_a & init_done;
  assign acc_b = en_b & init_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      clr_cnt   <= '0;
      init_done <= (CLEAR_ON_RESET == 0);
    end else begin
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (clr_cnt == '1) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN:   state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  // B lanes are written first so a colliding A lane overrides them.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < NB; i++)
        if (acc_b && we_b[i]) mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= di_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      for (int i = 0; i < NB; i++)
        if (acc_a && we_a[i]) mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= di_a[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Cross-port reads always see prior contents; only the own port's lanes forward.
  always_comb begin
    rd_a = mem[addr_a];
    rd_b = mem[addr_b];
    if (RDW_NEW != 0) begin
      for (int i = 0; i < NB; i++) begin
        if (we_a[i]) rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = di_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (we_b[i]) rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = di_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_a <= '0;
      q1_b <= '0;
      v1_a <= 1'b0;
      v1_b <= 1'b0;
    end else begin
      v1_a <= acc_a;
      v1_b <= acc_b;
      if (acc_a) q1_a <= rd_a;
      if (acc_b) q1_b <= rd_b;
    end
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic [DATA_WIDTH-1:0] q2_a, q2_b;
      logic                  v2_a, v2_b;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q2_a <= '0;
          q2_b <= '0;
          v2_a <= 1'b0;
          v2_b <= 1'b0;
        end else begin
          v2_a <= v1_a;
          v2_b <= v1_b;
          if (v1_a) q2_a <= q1_a;
          if (v1_b) q2_b <= q1_b;
        end
      end
      assign do_a    = q2_a;
      assign do_b    = q2_b;
      assign valid_a = v2_a;
      assign valid_b = v2_b;
    end else begin : g_direct
      assign do_a    = q1_a;
      assign do_b    = q1_b;
      assign valid_a = v1_a;
      assign valid_b = v1_b;
    end
  endgenerate

endmodule

// File: tb/tb_dpram_generic.sv
// Drives two RAM variants (latency 1 / new-data, latency 2 / old-data) with shared
// stimulus and compares both against a word-array reference model every cycle.
module tb_dpram_generic;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_a, en_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [NB-1:0] we_a, we_b;
  logic [DW-1:0] di_a, di_b;

  logic          init0, init1;
  logic [DW-1:0] do0_a, do0_b, do1_a, do1_b;
  logic          v0_a, v0_b, v1_a, v1_b;

  always #5 clk = ~clk;

  dpram_generic #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
                  .OUTREG(0), .RDW_NEW(1), .CLEAR_ON_RESET(1)) u_d0 (
    .clk(clk), .rst(rst), .init_done(init0),
    .en_a(en_a), .addr_a(addr_a), .we_a(we_a), .di_a(di_a), .do_a(do0_a), .valid_a(v0_a),
    .en_b(en_b), .addr_b(addr_b), .we_b(we_b), .di_b(di_b), .do_b(do0_b), .valid_b(v0_b)
  );

  dpram_generic #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
                  .OUTREG(1), .RDW_NEW(0), .CLEAR_ON_RESET(1)) u_d1 (
    .clk(clk), .rst(rst), .init_done(init1),
    .en_a(en_a), .addr_a(addr_a), .we_a(we_a), .di_a(di_a), .do_a(do1_a), .valid_a(v1_a),
    .en_b(en_b), .addr_b(addr_b), .we_b(we_b), .di_b(di_b), .do_b(do1_b), .valid_b(v1_b)
  );

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  int            since;
  logic          e_init;
  logic [DW-1:0] e_do0_a, e_do0_b, e_do1_a, e_do1_b;
  logic          e_v0_a, e_v0_b, e_v1_a, e_v1_b;
  logic          p_v_a, p_v_b;
  logic [DW-1:0] p_d_a, p_d_b;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NB-1:0] we);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++)
      if (we[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  task automatic reset_model();
    since = 0;
    e_init = 1'b0;
    e_do0_a = '0; e_do0_b = '0; e_do1_a = '0; e_do1_b = '0;
    e_v0_a = 1'b0; e_v0_b = 1'b0; e_v1_a = 1'b0; e_v1_b = 1'b0;
    p_v_a = 1'b0; p_v_b = 1'b0; p_d_a = '0; p_d_b = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic check_all();
    chk("init0", init0, e_init);
    chk("init1", init1, e_init);
    chk("v0_a", v0_a, e_v0_a);
    chk("v0_b", v0_b, e_v0_b);
    chk("v1_a", v1_a, e_v1_a);
    chk("v1_b", v1_b, e_v1_b);
    chk("do0_a", do0_a, e_do0_a);
    chk("do0_b", do0_b, e_do0_b);
    chk("do1_a", do1_a, e_do1_a);
    chk("do1_b", do1_b, e_do1_b);
  endtask

  // Advance one clock: model the edge with current inputs, then compare outputs.
  task automatic step();
    logic          acc_a, acc_b;
    logic [DW-1:0] old_a, old_b;
    if (rst) begin
      reset_model();
    end else begin
      acc_a = en_a && e_init;
      acc_b = en_b && e_init;
      old_a = ref_mem[addr_a];
      old_b = ref_mem[addr_b];
      if (acc_b) ref_mem[addr_b] = merge(ref_mem[addr_b], di_b, we_b);
      if (acc_a) ref_mem[addr_a] = merge(ref_mem[addr_a], di_a, we_a);
      e_v0_a = acc_a;
      e_v0_b = acc_b;
      if (acc_a) e_do0_a = merge(old_a, di_a, we_a);
      if (acc_b) e_do0_b = merge(old_b, di_b, we_b);
      e_v1_a = p_v_a;
      e_v1_b = p_v_b;
      if (p_v_a) e_do1_a = p_d_a;
      if (p_v_b) e_do1_b = p_d_b;
      p_v_a = acc_a; p_d_a = old_a;
      p_v_b = acc_b; p_d_b = old_b;
      since++;
      e_init = (since >= DEPTH);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_a(input logic en, input logic [AW-1:0] ad, input logic [NB-1:0] we,
                       input logic [DW-1:0] di);
    en_a = en; addr_a = ad; we_a = we; di_a = di;
  endtask

  task automatic set_b(input logic en, input logic [AW-1:0] ad, input logic [NB-1:0] we,
                       input logic [DW-1:0] di);
    en_b = en; addr_b = ad; we_b = we; di_b = di;
  endtask

  task automatic idle();
    set_a(1'b0, '0, '0, '0);
    set_b(1'b0, '0, '0, '0);
  endtask

  // Asserted away from the clock edge; outputs must clear asynchronously.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    reset_model();
    check_all();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      set_a(($urandom_range(0, 3) != 0), AW'($urandom), NB'($urandom), $urandom);
      set_b(($urandom_range(0, 3) != 0), AW'($urandom), NB'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) addr_b = addr_a;
      if ($urandom_range(0, 5) == 0) we_a = '0;
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    do_reset();
    repeat (DEPTH) step();
    chk("init_after_clear", init0, 1'b1);

    random_phase(300);

    // Reset one cycle after a read is issued: the latency-2 read must vanish.
    set_a(1'b1, 4'd9, 4'h0, '0);
    set_b(1'b0, '0, '0, '0);
    step();
    idle();
    do_reset();
    chk("rst_v1_a", v1_a, 1'b0);
    chk("rst_init", init0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      step();
      chk("clear_wait", init0, 1'b0);
    end
    step();
    chk("clear_done", init0, 1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      set_a(1'b1, AW'(i), '0, $urandom);
      set_b(1'b1, AW'(DEPTH - 1 - i), '0, $urandom);
      step();
      chk("clear_rd_a", do0_a, 32'h0);
      chk("clear_rd_b", do0_b, 32'h0);
    end
    idle();
    step();

    // Byte-lane writes
    set_a(1'b1, 4'd3, 4'hF, 32'h11223344); step();
    set_a(1'b1, 4'd3, 4'b0101, 32'hAABBCCDD); step();
    idle();
    set_b(1'b1, 4'd3, 4'h0, 32'h0); step();
    chk("bytewr_lat1", do0_b, 32'h11BB33DD);
    idle(); step();
    chk("bytewr_lat2", do1_b, 32'h11BB33DD);

    // Same-port read-during-write on a cleared word
    set_a(1'b1, 4'd5, 4'b0011, 32'hFFFFFFFF); step();
    chk("rdw_new", do0_a, 32'h0000FFFF);
    idle(); step();
    chk("rdw_old", do1_a, 32'h00000000);

    // Same-address write collision
    set_a(1'b1, 4'd7, 4'b1100, 32'h12345678);
    set_b(1'b1, 4'd7, 4'b0110, 32'h9ABCDEF0);
    step();
    idle();
    set_a(1'b1, 4'd7, 4'h0, 32'h0); step();
    chk("collide", do0_a, 32'h1234DE00);
    idle(); step();

    // Output-register pipeline
    set_a(1'b1, 4'd0, 4'hF, 32'd10); step();
    set_a(1'b1, 4'd1, 4'hF, 32'd20); step();
    set_a(1'b1, 4'd2, 4'hF, 32'd30); step();
    idle();
    set_b(1'b1, 4'd0, 4'h0, '0); step();
    chk("or_v_c1", v1_b, 1'b0);
    set_b(1'b1, 4'd1, 4'h0, '0); step();
    chk("or_v_c2", v1_b, 1'b1); chk("or_d_c2", do1_b, 32'd10);
    set_b(1'b1, 4'd2, 4'h0, '0); step();
    chk("or_v_c3", v1_b, 1'b1); chk("or_d_c3", do1_b, 32'd20);
    idle(); step();
    chk("or_v_c4", v1_b, 1'b1); chk("or_d_c4", do1_b, 32'd30);
    step();
    chk("or_v_c5", v1_b, 1'b0); chk("or_hold", do1_b, 32'd30);

    random_phase(200);
    idle();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dpram_generic.md
Name: dpram_generic

Overview:
- Parametrised, vendor-neutral true dual-port RAM with per-byte write enables, synchronous to one clock.
- Adds what the fixed 16x32 Altera instance lacks:
  - generic width and depth;
  - selectable read-during-write mode;
  - optional output register;
  - per-port read-valid strobes;
  - deterministic collision resolution;
  - a post-reset clear sequencer that zeroes the array.
- Used as the buffer RAM between the Wishbone side and the SDRAM controller core.

Parameters:
- ADDR_WIDTH, 4: address bits. Depth DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width. Must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per byte-enable lane. NB = DATA_WIDTH/BYTE_WIDTH.
- OUTREG, 0: 0 = read latency 1; 1 = extra output register, read latency 2.
- RDW_NEW, 1: same-port read-during-write. 1 = new data with old unwritten bytes; 0 = old data.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset before accepting accesses.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- init_done  out  1  high when ports accept accesses
- en_a  in  1  port A access enable (read and/or write)
- addr_a  in  ADDR_WIDTH  port A word address
- we_a  in  NB  port A byte write enables, qualified by en_a
- di_a  in  DATA_WIDTH  port A write data
- do_a  out  DATA_WIDTH  port A read data
- valid_a  out  1  do_a holds data for a read issued LAT cycles earlier
- en_b, addr_b, we_b, di_b, do_b, valid_b: identical to port A, for port B

Behaviour:
- Reset values (async):
  - do_a/do_b = 0; valid_a/valid_b = 0; clear counter = 0.
  - init_done = 0 if CLEAR_ON_RESET=1, else 1.
  - FSM = CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Array contents are not reset asynchronously.
- FSM CLEAR:
  - Writes all-zero to word clr_cnt each cycle; clr_cnt increments 0..DEPTH-1.
  - Port inputs are ignored; valid_x stays 0.
  - After writing DEPTH-1, goes to RUN. init_done rises on that same edge, so it is high DEPTH cycles after reset release.
- FSM RUN:
  - Stays in RUN until rst.
  - Port accesses take effect only when en_x=1 and init_done=1.
- Read:
  - Every enabled access is a read. LAT = 1 + OUTREG.
  - valid_x is en_x delayed by LAT cycles. do_x updates only when the corresponding valid_x is 1, otherwise it holds.
- Write:
  - Byte lane i is written with di_x[i*BYTE_WIDTH +: BYTE_WIDTH] when en_x and we_x[i]; other lanes are untouched.
  - en_x=1 with we_x=0 is a pure read.
- Same-port read-during-write:
  - RDW_NEW=1: returned word has written lanes = new data, unwritten lanes = prior contents.
  - RDW_NEW=0: returned word = prior contents.
- Cross-port, same address, A writes while B reads (or the reverse): the reader returns prior contents, regardless of RDW_NEW.
- Both ports write the same address in the same cycle, per lane:
  - lane enabled by A: A's data (A wins);
  - enabled by B only: B's data;
  - enabled by neither: unchanged.
- Address wrap: the address is exactly ADDR_WIDTH bits; there is no out-of-range case.
- Reset mid-operation:
  - In-flight reads are discarded (valid_x = 0).
  - A write in the reset cycle may or may not land.
  - With CLEAR_ON_RESET=1, clear restarts from word 0.
- Output register stage (OUTREG=1): the registered stage loads from the first stage only when the pipelined enable is set; do_x holds otherwise.

Test Plan:
- Clear:
  - Stimulus: CLEAR_ON_RESET=1, ADDR_WIDTH=4; preload garbage via a first run; pulse rst; then read all 16 addresses.
  - Required: init_done high exactly 16 cycles after rst release; all reads return 32'h0; valid pulses 1 cycle after each en (OUTREG=0).
- Byte write:
  - Stimulus: A writes 32'h11223344 to addr 3 with we=4'hF; then A writes 32'hAABBCCDD to addr 3 with we=4'b0101; then B reads addr 3.
  - Required: do_b = 32'h11BB33DD.
- Same-port read-during-write:
  - Stimulus: addr 5 holds 32'h00000000; A writes 32'hFFFFFFFF with we=4'b0011.
  - Required: do_a = 32'h0000FFFF with RDW_NEW=1; do_a = 32'h00000000 with RDW_NEW=0.
- Collision:
  - Stimulus: same cycle, A writes 32'h12345678 to addr 7 with we=4'b1100; B writes 32'h9ABCDEF0 to addr 7 with we=4'b0110; then read addr 7.
  - Required: 32'h1234DE??, where ?? = prior byte 0. If prior byte 0 is 8'h00, the result is 32'h1234DE00.
- Output register:
  - Stimulus: OUTREG=1; back-to-back reads of addrs 0,1,2 holding 10, 20, 30.
  - Required: valid_b high on cycles 2-4 after the first en; do_b = 10, 20, 30 on those cycles; do_b holds 30 afterward.
- Reset mid-read:
  - Stimulus: assert rst one cycle after en_a.
  - Required: valid_a never asserts; do_a = 0; clear restarts and init_done drops to 0.
